// File: rtl/skid_pkg.sv
// Shared types for the skid pipeline register.
// No logic of its own; imported by the skid_pipe_reg files.
// No flow control here; the enum encodes the entry count held in the stage.
package skid_pkg;

  // Entry-count state: nothing held, main only, main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/skid_entry.sv
// One WIDTH-bit storage entry with load enable and synchronous reset to RESET_VAL.
// Latency: 1 cycle from en/d to q.
// No backpressure of its own; the owner decides when to load.
module skid_entry #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset wins over a load so entries held mid-transfer are discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/skid_pipe_reg.sv
// Two-entry skid pipeline register (main + skid) with fully registered handshakes.
// Latency: 1 cycle in_data -> out_data when main is empty or popped in the same cycle.
// Backpressure: in_ready drops only once both entries are full; no out_ready->in_ready path.
// Optional flush port is compiled in when SKID_FLUSH_EN is defined.
module skid_pipe_reg
  import skid_pkg::*;
#(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
`ifdef SKID_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_t      state;
  skid_state_t      state_nxt;
  logic             push;
  logic             pop;
  logic             flush_int;
  logic             main_en;
  logic             main_from_skid;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;

`ifdef SKID_FLUSH_EN
  assign flush_int = flush;
`else
  assign flush_int = 1'b0;
`endif

  // Handshakes use the registered in_ready/out_valid, so push/pop never loop back.
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // On refill from TWO the skid entry moves into main; otherwise main takes the input.
  assign main_d = main_from_skid ? skid_q : in_data;

  // Next-state and entry-load decode; skid is written only when main stays occupied.
  always_comb begin
    state_nxt      = state;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    if (flush_int) begin
      // Drop everything, including a same-cycle push; main keeps its old value.
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state_nxt = ONE;
            main_en   = 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_en = 1'b1;
          end else if (push) begin
            state_nxt = TWO;
            skid_en   = 1'b1;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_nxt      = ONE;
            main_en        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: begin
          state_nxt = EMPTY;
        end
      endcase
    end
  end

  // State plus dedicated ready/valid flops derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != TWO);
      out_valid <= (state_nxt != EMPTY);
    end
  end

  skid_entry #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk   (clk),
    .reset (reset),
    .en    (main_en),
    .d     (main_d),
    .q     (out_data)
  );

  skid_entry #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (skid_en),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule
